fft_result_streamer: RTL and testbench



---
 rtl/fft_stream_pkg.sv | 25 ++
 rtl/fft_result_streamer_stream_fifo.sv | 59 +++++
 rtl/fft_result_streamer.sv | 193 +++++++++++++++++++
 tb/tb_fft_result_streamer.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_stream_pkg.sv
// Shared constants, FSM state type and bit-reverse helper for the FFT result streamer.
// Build option: FFT_STREAM_CHECKSUM_EN adds a per-channel checksum beat at frame end.
package fft_stream_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 9;
  localparam int N_CH_DEF   = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Reverses the low 'width' bits of value; bits above 'width' come back as zero.
  function automatic logic [31:0] bitrev(input logic [31:0] value, input int width);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < width) r = {r[30:0], value[i]};
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_result_streamer_stream_fifo.sv
// Small register-based synchronous FIFO that absorbs returning BRAM reads
// while the downstream consumer stalls.
module stream_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             pop_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign pop_ok = i_pop && !o_empty;

  // NOTE: storage is reset along with the pointers so the head word (and o_data)
  // reads as zero after reset; this is affordable only because the FIFO is tiny.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (i_push) begin
        mem_q[wr_ptr_q] <= i_data;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop_ok) rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({i_push, pop_ok})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign o_data  = mem_q[rd_ptr_q];
  assign o_empty = (count_q == '0);
  assign o_full  = (count_q == CNT_W'(DEPTH));
  assign o_count = count_q;

endmodule

// File: rtl/fft_result_streamer.sv
// Dumps N_CH parallel FFT result banks as a valid/ready stream, natural or bit-reversed order.
// Build option: FFT_STREAM_CHECKSUM_EN appends a per-channel sum beat carrying o_last.
module fft_result_streamer
  import fft_stream_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int N_CH   = N_CH_DEF,
  parameter int RD_LAT = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_start,
  input  logic                   i_bitrev,
  output logic                   o_busy,
  output logic                   o_rd_en,
  output logic [ADDR_W-1:0]      o_rd_addr,
  input  logic [N_CH*DATA_W-1:0] i_rd_data,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [N_CH*DATA_W-1:0] o_data,
  output logic [ADDR_W-1:0]      o_index,
  output logic                   o_last
);

  localparam int DEPTH      = 2 ** ADDR_W;
  localparam int PAY_W      = N_CH * DATA_W;
  localparam int ENT_W      = PAY_W + ADDR_W + 1;
  localparam int FIFO_DEPTH = RD_LAT + 1;
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);

  state_t            state_q, state_d;
  logic [ADDR_W:0]   k_q, k_d;
  logic              bitrev_q, bitrev_d;

  // Reads in flight through the BRAM, each tagged with its bin index and last flag.
  logic [RD_LAT-1:0] pend_q;
  logic [RD_LAT-1:0] pend_last_q;
  logic [ADDR_W-1:0] pend_idx_q [RD_LAT];

  logic              start_acc, k_last, issue, credit_ok;
  logic              push, pop, final_accept;
  int                inflight;

  logic [ENT_W-1:0]  fifo_dout;
  logic              fifo_full, fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [PAY_W-1:0]  fifo_pay;
  logic [ADDR_W-1:0] fifo_idx;
  logic              fifo_last;

  assign start_acc = i_start && (state_q == IDLE);
  assign k_last    = (k_q == (ADDR_W + 1)'(DEPTH - 1));
  assign push      = pend_q[RD_LAT-1];
  assign pop       = !fifo_empty && i_ready;

  assign {fifo_last, fifo_idx, fifo_pay} = fifo_dout;

  // A read is issued only if its data is guaranteed a FIFO slot on return;
  // the word leaving this cycle already frees its slot.
  always_comb begin
    inflight = 0;
    for (int i = 0; i < RD_LAT; i++) inflight += int'(pend_q[i]);
    credit_ok = (int'(fifo_count) + inflight - (pop ? 1 : 0)) < FIFO_DEPTH;
  end

  assign issue     = (state_q == ISSUE) && credit_ok;
  assign o_rd_en   = issue;
  assign o_rd_addr = bitrev_q ? ADDR_W'(bitrev(32'(k_q[ADDR_W-1:0]), ADDR_W))
                              : k_q[ADDR_W-1:0];
  assign o_busy    = (state_q != IDLE);

  // NOTE: every always_comb output gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    bitrev_d = bitrev_q;
    case (state_q)
      IDLE: begin
        if (start_acc) begin
          state_d  = ISSUE;
          k_d      = '0;
          bitrev_d = i_bitrev;
        end
      end
      ISSUE: begin
        if (issue) begin
          k_d = k_q + (ADDR_W + 1)'(1);
          if (k_last) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (final_accept) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // sees the pre-edge value of every other register regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      k_q         <= '0;
      bitrev_q    <= 1'b0;
      pend_q      <= '0;
      pend_last_q <= '0;
      for (int i = 0; i < RD_LAT; i++) pend_idx_q[i] <= '0;
    end else begin
      state_q        <= state_d;
      k_q            <= k_d;
      bitrev_q       <= bitrev_d;
      pend_q[0]      <= issue;
      pend_idx_q[0]  <= k_q[ADDR_W-1:0];
      pend_last_q[0] <= k_last;
      for (int i = 1; i < RD_LAT; i++) begin
        pend_q[i]      <= pend_q[i-1];
        pend_idx_q[i]  <= pend_idx_q[i-1];
        pend_last_q[i] <= pend_last_q[i-1];
      end
    end
  end

  stream_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (push),
    .i_data  ({pend_last_q[RD_LAT-1], pend_idx_q[RD_LAT-1], i_rd_data}),
    .i_pop   (pop),
    .o_data  (fifo_dout),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_count (fifo_count)
  );

  // The credit scheme must make a push into a full FIFO impossible.
  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
    push |-> (!fifo_full || pop));

`ifdef FFT_STREAM_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q [N_CH];
  logic [PAY_W-1:0]  sum_bus;
  logic              csum_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csum_q <= 1'b0;
      for (int ch = 0; ch < N_CH; ch++) sum_q[ch] <= '0;
    end else if (start_acc) begin
      csum_q <= 1'b0;
      for (int ch = 0; ch < N_CH; ch++) sum_q[ch] <= '0;
    end else begin
      if (pop) begin
        for (int ch = 0; ch < N_CH; ch++)
          sum_q[ch] <= sum_q[ch] + fifo_pay[ch*DATA_W +: DATA_W];
        if (fifo_last) csum_q <= 1'b1;
      end else if (csum_q && i_ready) begin
        csum_q <= 1'b0;
      end
    end
  end

  always_comb begin
    sum_bus = '0;
    for (int ch = 0; ch < N_CH; ch++) sum_bus[ch*DATA_W +: DATA_W] = sum_q[ch];
  end

  // The sum beat follows the last bin; the FIFO is empty by then so it owns the port.
  always_comb begin
    o_valid = csum_q || !fifo_empty;
    o_data  = csum_q ? sum_bus : fifo_pay;
    o_index = csum_q ? '0 : fifo_idx;
    o_last  = csum_q;
  end

  assign final_accept = csum_q && i_ready;
`else
  always_comb begin
    o_valid = !fifo_empty;
    o_data  = fifo_pay;
    o_index = fifo_idx;
    o_last  = !fifo_empty && fifo_last;
  end

  assign final_accept = pop && fifo_last;
`endif

endmodule

// File: tb/tb_fft_result_streamer.sv
// Self-checking bench for fft_result_streamer: BRAM model, random ready, frame-level reference.
module tb_fft_result_streamer;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 9;
  localparam int N_CH   = 2;
  localparam int RD_LAT = 1;
  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int PAY_W  = N_CH * DATA_W;
`ifdef FFT_STREAM_CHECKSUM_EN
  localparam int FRAME  = DEPTH + 1;
`else
  localparam int FRAME  = DEPTH;
`endif

  logic              clk, rst;
  logic              i_start, i_bitrev, i_ready;
  logic              o_busy, o_rd_en, o_valid, o_last;
  logic [ADDR_W-1:0] o_rd_addr, o_index;
  logic [PAY_W-1:0]  i_rd_data, o_data;

  int checks   = 0;
  int failures = 0;

  logic [15:0]       mem_re [DEPTH];
  logic [15:0]       mem_im [DEPTH];
  logic [PAY_W-1:0]  rd_pipe [RD_LAT];

  logic [PAY_W-1:0]  exp_data [FRAME];
  logic [ADDR_W-1:0] exp_idx  [FRAME];
  logic              exp_last [FRAME];
  logic [PAY_W-1:0]  cap_data [FRAME];
  logic              cap_last [FRAME];

  fft_result_streamer #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .N_CH   (N_CH),
    .RD_LAT (RD_LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .i_start   (i_start),
    .i_bitrev  (i_bitrev),
    .o_busy    (o_busy),
    .o_rd_en   (o_rd_en),
    .o_rd_addr (o_rd_addr),
    .i_rd_data (i_rd_data),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_data    (o_data),
    .o_index   (o_index),
    .o_last    (o_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Fixed-latency BRAM: address captured on o_rd_en, word appears RD_LAT cycles later.
  always @(posedge clk) begin
    if (o_rd_en) rd_pipe[0] <= {mem_im[o_rd_addr], mem_re[o_rd_addr]};
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign i_rd_data = rd_pipe[RD_LAT-1];

  function automatic int tb_bitrev(input int v);
    int r = 0;
    for (int i = 0; i < ADDR_W; i++) r = (r << 1) | ((v >> i) & 1);
    return r;
  endfunction

  task automatic preload(input bit rnd);
    for (int a = 0; a < DEPTH; a++) begin
      mem_re[a] = rnd ? 16'($urandom) : 16'(a);
      mem_im[a] = rnd ? 16'($urandom) : 16'(-a);
    end
  endtask

  task automatic build_expected(input bit br);
    logic [15:0] sr, si;
    int a;
    sr = '0;
    si = '0;
    for (int k = 0; k < DEPTH; k++) begin
      a = br ? tb_bitrev(k) : k;
      exp_data[k] = {mem_im[a], mem_re[a]};
      exp_idx[k]  = ADDR_W'(k);
      exp_last[k] = (k == FRAME - 1);
      sr = sr + mem_re[a];
      si = si + mem_im[a];
    end
`ifdef FFT_STREAM_CHECKSUM_EN
    exp_data[DEPTH] = {si, sr};
    exp_idx[DEPTH]  = '0;
    exp_last[DEPTH] = 1'b1;
`endif
  endtask

  // Runs one frame; restart_at / abort_at < 0 disable those events.
  task automatic run_frame(input bit br, input int ready_pct, input int restart_at,
                           input bit restart_last, input int abort_at);
    int beat = 0, cyc = 0, first = -1, lastc = -1;
    bit stall = 1'b0;
    logic [PAY_W-1:0]  pd;
    logic [ADDR_W-1:0] pi;
    logic              pl;
    build_expected(br);
    @(negedge clk);
    i_start  = 1'b1;
    i_bitrev = br;
    i_ready  = 1'b0;
    while (beat < FRAME && cyc < 20 * FRAME) begin
      @(negedge clk);
      cyc++;
      i_start = 1'b0;
      if (cyc == 1) begin
        checks++;
        if (o_busy !== 1'b1) begin
          failures++;
          $display("FAIL busy_after_start got=%b exp=1", o_busy);
        end
      end
      if (stall) begin
        checks++;
        if (o_valid !== 1'b1 || o_data !== pd || o_index !== pi || o_last !== pl) begin
          failures++;
          $display("FAIL stable_while_stalled v=%b data=%h/%h idx=%0d/%0d last=%b/%b",
                   o_valid, o_data, pd, o_index, pi, o_last, pl);
        end
      end
      if (beat == abort_at) begin
        i_ready = 1'b0;
        return;
      end
      i_ready = ($urandom_range(0, 99) < ready_pct);
      if (o_valid === 1'b1 && first < 0) first = cyc;
      if (o_valid === 1'b1 && i_ready) begin
        checks++;
        if (o_data !== exp_data[beat] || o_index !== exp_idx[beat] || o_last !== exp_last[beat]) begin
          failures++;
          $display("FAIL beat k=%0d got data=%h idx=%0d last=%b exp data=%h idx=%0d last=%b",
                   beat, o_data, o_index, o_last, exp_data[beat], exp_idx[beat], exp_last[beat]);
        end
        cap_data[beat] = o_data;
        cap_last[beat] = o_last;
        if (beat == restart_at) i_start = 1'b1;
        if (beat == FRAME - 1) begin
          lastc = cyc;
          if (restart_last) i_start = 1'b1;
        end
        beat++;
      end
      stall = (o_valid === 1'b1) && !i_ready;
      pd = o_data;
      pi = o_index;
      pl = o_last;
    end
    checks++;
    if (beat != FRAME) begin
      failures++;
      $display("FAIL frame_timeout beats=%0d exp=%0d", beat, FRAME);
      return;
    end
    // Start is sampled at the edge ending cycle 0, so first o_valid is RD_LAT+1 edges later.
    checks++;
    if (first - 1 != RD_LAT + 1) begin
      failures++;
      $display("FAIL first_valid_latency got=%0d exp=%0d", first - 1, RD_LAT + 1);
    end
    if (ready_pct == 100) begin
      checks++;
      if (lastc - first != FRAME - 1) begin
        failures++;
        $display("FAIL throughput span got=%0d exp=%0d", lastc - first, FRAME - 1);
      end
    end
    @(negedge clk);
    i_start = 1'b0;
    i_ready = 1'b1;
    checks++;
    if (o_busy !== 1'b0) begin
      failures++;
      $display("FAIL busy_after_last got=%b exp=0", o_busy);
    end
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      checks++;
      if (o_valid !== 1'b0 || o_rd_en !== 1'b0 || o_busy !== 1'b0) begin
        failures++;
        $display("FAIL idle_after_frame cyc=%0d valid=%b rd_en=%b busy=%b exp=0/0/0",
                 c, o_valid, o_rd_en, o_busy);
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    checks++;
    if ({o_busy, o_rd_en, o_rd_addr, o_valid, o_data, o_index, o_last} !== '0) begin
      failures++;
      $display("FAIL %s busy=%b rd_en=%b addr=%0d valid=%b data=%h idx=%0d last=%b exp all 0",
               tag, o_busy, o_rd_en, o_rd_addr, o_valid, o_data, o_index, o_last);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    i_start = 1'b0;
    i_bitrev = 1'b0;
    i_ready = 1'b0;
    #23;
    check_all_zero("reset_values");
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check_all_zero("idle_after_reset");
    end
  endtask

  task automatic test_natural();
    preload(1'b0);
    run_frame(1'b0, 100, -1, 1'b0, -1);
    checks++;
    if (cap_data[5] !== {16'(-5), 16'd5}) begin
      failures++;
      $display("FAIL natural_beat5 got=%h exp=%h", cap_data[5], {16'(-5), 16'd5});
    end
`ifdef FFT_STREAM_CHECKSUM_EN
    checks++;
    if (cap_data[DEPTH][15:0] !== 16'd65280 || cap_last[DEPTH] !== 1'b1 || cap_last[DEPTH-1] !== 1'b0) begin
      failures++;
      $display("FAIL checksum_beat real=%0d last=%b prev_last=%b exp 65280/1/0",
               cap_data[DEPTH][15:0], cap_last[DEPTH], cap_last[DEPTH-1]);
    end
`else
    checks++;
    if (cap_last[DEPTH-1] !== 1'b1 || cap_last[DEPTH-2] !== 1'b0) begin
      failures++;
      $display("FAIL last_on_511 got=%b/%b exp=1/0", cap_last[DEPTH-1], cap_last[DEPTH-2]);
    end
`endif
  endtask

  task automatic test_bitrev();
    preload(1'b0);
    run_frame(1'b1, 100, -1, 1'b0, -1);
    checks++;
    if (cap_data[1][15:0] !== 16'd256 || cap_data[3][15:0] !== 16'd384) begin
      failures++;
      $display("FAIL bitrev_spot k1=%0d k3=%0d exp 256/384", cap_data[1][15:0], cap_data[3][15:0]);
    end
  endtask

  task automatic test_random_ready();
    preload(1'b1);
    run_frame(1'b0, 50, -1, 1'b0, -1);
    preload(1'b1);
    run_frame(1'b1, 30, -1, 1'b0, -1);
  endtask

  task automatic test_back_to_back_start();
    preload(1'b1);
    run_frame(1'b0, 100, 100, 1'b1, -1);
  endtask

  task automatic test_reset_abort();
    preload(1'b0);
    run_frame(1'b0, 100, -1, 1'b0, 200);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("async_abort");
    @(negedge clk);
    rst = 1'b0;
    i_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check_all_zero("quiet_after_abort");
    end
    run_frame(1'b0, 100, -1, 1'b0, -1);
  endtask

  initial begin
    test_reset();
    test_natural();
    test_bitrev();
    test_random_ready();
    test_back_to_back_start();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
